// File: rtl/ha_pkg.sv
// Shared definitions for the half-adder result packer: counter width helper,
// default word layout and the flush state encoding.
package ha_pkg;

  localparam int HA_W = 8;

  // Width of a counter that must hold 0..w inclusive.
  function automatic int ha_cw(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int HA_CW = ha_cw(HA_W);

  typedef struct packed {
    logic [HA_W-1:0]  data;
    logic [HA_CW-1:0] ccount;
    logic [HA_CW-1:0] nbits;
  } ha_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH_WAIT
  } ha_state_t;

endpackage

// File: rtl/ha_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module ha_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  T            mem [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Head reads as zero while empty so stale entries never leak out.
  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/ha_result_packer.sv
// Packs half-adder sum bits LSB-first into W-bit words, counts carries per
// word, and queues completed or flushed words in a small valid/ready FIFO.
module ha_result_packer
  import ha_pkg::*;
#(
  parameter int W     = HA_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sum,
  input  logic                   in_carry,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(W+1)-1:0] out_ccount,
  output logic [$clog2(W+1)-1:0] out_nbits
);

  localparam int CW = ha_cw(W);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] ccount;
    logic [CW-1:0] nbits;
  } word_t;

  ha_state_t     state_q, state_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [CW-1:0] ccount_q, ccount_d;
  logic [W-1:0]  shreg_q, shreg_d;

  logic          accept, complete, emit_req, flush_pend;
  logic [W-1:0]  bit_sel, shreg_a;
  logic [CW-1:0] cnt_a, cc_a;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  word_t         fifo_din, fifo_dout;

  assign flush_pend = (state_q == ST_FLUSH_WAIT);
  assign in_ready   = !(fifo_full && ((bitcnt_q == CW'(W-1)) || flush_pend));
  assign accept     = in_valid && in_ready;

  // One-hot write enable for the bit slot addressed by bitcnt.
  for (genvar gi = 0; gi < W; gi++) begin : g_sel
    assign bit_sel[gi] = accept && (bitcnt_q == CW'(gi));
  end

  // "_a" values include the bit accepted this cycle, if any.
  assign shreg_a  = shreg_q | ({W{in_sum}} & bit_sel);
  assign cnt_a    = bitcnt_q + CW'(accept);
  assign cc_a     = ccount_q + CW'(accept && in_carry);
  assign complete = accept && (bitcnt_q == CW'(W-1));
  assign emit_req = complete || ((flush || flush_pend) && (cnt_a != '0));

  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = emit_req && (!fifo_full || fifo_pop);

  always_comb begin
    fifo_din        = '0;
    fifo_din.data   = shreg_a;
    fifo_din.ccount = cc_a;
    fifo_din.nbits  = cnt_a;
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = cnt_a;
    ccount_d = cc_a;
    shreg_d  = shreg_a;
    if (fifo_push) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      ccount_d = '0;
      shreg_d  = '0;
    end else if (emit_req) begin
      // Only a flush can be blocked: completion is gated off by in_ready.
      state_d = ST_FLUSH_WAIT;
    end else if (cnt_a != '0) begin
      state_d = ST_FILL;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      ccount_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      ccount_q <= ccount_d;
      shreg_q  <= shreg_d;
    end
  end

  ha_sync_fifo #(
    .T     (word_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_dout.data;
  assign out_ccount = fifo_dout.ccount;
  assign out_nbits  = fifo_dout.nbits;

endmodule

// File: tb/tb_ha_result_packer.sv
// Directed bench for ha_result_packer: expected words are queued as stimulus
// is issued and a negedge monitor pops them on every output handshake.
module tb_ha_result_packer;

  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sum, in_carry, flush;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ccount, out_nbits;

  typedef struct {
    int d;
    int cc;
    int nb;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ha_result_packer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ccount (out_ccount),
    .out_nbits  (out_nbits)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int d, input int cc, input int nb);
    exp_t e;
    e.d = d; e.cc = cc; e.nb = nb;
    exp_q.push_back(e);
  endtask

  // Monitor: one line per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got data=0x%0h cc=%0d nb=%0d expected none",
                 out_data, out_ccount, out_nbits);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("word data=0x%02h cc=%0d nb=%0d (exp 0x%02h/%0d/%0d)",
                 out_data, out_ccount, out_nbits, e.d, e.cc, e.nb);
        chk("out_data", int'(out_data), e.d);
        chk("out_ccount", int'(out_ccount), e.cc);
        chk("out_nbits", int'(out_nbits), e.nb);
      end
    end
  end

  // All drivers run at posedge+1 and return there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic c, input logic f);
    int n;
    in_valid = 1'b1; in_sum = s; in_carry = c; flush = f;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout_in_ready", 0, 1);
    tick();
    in_valid = 1'b0; flush = 1'b0; in_sum = 1'b0; in_carry = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] s, input logic [7:0] c);
    for (int i = 0; i < 8; i++) send(s[i], c[i], 1'b0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s1, c1;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_sum = 1'b0; in_carry = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ccount", int'(out_ccount), 0);
    chk("rst_out_nbits", int'(out_nbits), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // 1: full word, latency one cycle after the last accept
    s1 = 8'h4D; c1 = 8'b1001_0010;
    expect_word(8'h4D, 3, 8);
    for (int i = 0; i < 7; i++) send(s1[i], c1[i], 1'b0);
    chk("t1_valid_before", int'(out_valid), 0);
    send(s1[7], c1[7], 1'b0);
    chk("t1_valid_after", int'(out_valid), 1);
    repeat (2) tick();

    // 2: partial word flush, then a flush with nothing pending
    expect_word(8'h07, 3, 3);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0);
    pulse_flush();
    repeat (3) tick();
    pulse_flush();
    repeat (3) tick();
    chk("t2_no_empty_word", int'(out_valid), 0);

    // 3: fill the FIFO with out_ready low; in_ready drops only at bitcnt==7
    out_ready = 1'b0;
    expect_word(8'hA5, 4, 8);
    expect_word(8'h3C, 4, 8);
    expect_word(8'h81, 1, 8);
    s1 = 8'hA5; c1 = 8'h0F;
    for (int i = 0; i < 8; i++) begin chk("t3_ready_a", int'(in_ready), 1); send(s1[i], c1[i], 1'b0); end
    s1 = 8'h3C; c1 = 8'hF0;
    for (int i = 0; i < 8; i++) begin chk("t3_ready_b", int'(in_ready), 1); send(s1[i], c1[i], 1'b0); end
    s1 = 8'h81; c1 = 8'h01;
    for (int i = 0; i < 7; i++) begin chk("t3_ready_c", int'(in_ready), 1); send(s1[i], c1[i], 1'b0); end
    chk("t3_ready_blocked", int'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_ready_released", int'(in_ready), 1);
    send(s1[7], c1[7], 1'b0);
    out_ready = 1'b1;
    repeat (4) tick();

    // 4: flush together with an accept, then flush on the completing bit
    expect_word(8'h1A, 2, 5);
    s1 = 8'h1A; c1 = 8'h14;
    for (int i = 0; i < 4; i++) send(s1[i], c1[i], 1'b0);
    send(s1[4], c1[4], 1'b1);
    expect_word(8'hB3, 1, 8);
    s1 = 8'hB3; c1 = 8'h80;
    for (int i = 0; i < 7; i++) send(s1[i], c1[i], 1'b0);
    send(s1[7], c1[7], 1'b1);
    repeat (4) tick();

    // 5: flush while full parks the partial word until a pop
    out_ready = 1'b0;
    expect_word(8'hFF, 0, 8);
    expect_word(8'h00, 8, 8);
    expect_word(8'h01, 2, 2);
    send_word(8'hFF, 8'h00);
    send_word(8'h00, 8'hFF);
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    chk("t5_ready_before_flush", int'(in_ready), 1);
    pulse_flush();
    chk("t5_ready_pending", int'(in_ready), 0);
    pulse_flush();
    repeat (3) tick();
    chk("t5_ready_still_pending", int'(in_ready), 0);
    chk("t5_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("t5_ready_after_pop", int'(in_ready), 1);
    repeat (6) tick();

    // 6: reset mid-operation discards everything
    out_ready = 1'b0;
    send_word(8'hC3, 8'h11);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0);
    chk("t6_valid_queued", int'(out_valid), 1);
    do_reset();
    chk("t6_valid_after_rst", int'(out_valid), 0);
    chk("t6_ready_after_rst", int'(in_ready), 1);
    out_ready = 1'b1;
    expect_word(8'h5A, 0, 8);
    send_word(8'h5A, 8'h00);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
